// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO in front of a UART transmitter, with launch pacing.
//
// Bytes arriving on i_DV/i_Byte are queued in a circular FIFO. A small FSM
// pops one byte at a time, pulses o_Tx_DV for one cycle, waits for the
// transmitter's i_Tx_Done, then idles CLKS_GUARD extra clocks before the next
// launch. Only one byte is ever in flight.
//
// Parameters
//   DEPTH       FIFO entries, power of 2 in 4..256
//   CLKS_GUARD  idle clocks between i_Tx_Done and the next launch, 0..15
// Ports
//   i_Clk        system clock, rising edge
//   rst          synchronous active-low reset
//   i_DV/i_Byte  one-cycle write strobe and data byte
//   i_Tx_Active  transmitter busy; holds off a launch while in idle
//   i_Tx_Done    transmitter completion pulse; only honoured while busy
//   o_Tx_DV      one-cycle launch strobe
//   o_Tx_Byte    byte being sent; held until the next launch
//   o_Count      FIFO occupancy; o_Full / o_Empty derived flags (registered)
//   o_Overflow   sticky: a write was dropped because the FIFO was full
module uart_tx_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CLKS_GUARD = 2
) (
  input  logic                     i_Clk,
  input  logic                     rst,
  input  logic                     i_DV,
  input  logic [7:0]               i_Byte,
  input  logic                     i_Tx_Active,
  input  logic                     i_Tx_Done,
  output logic                     o_Tx_DV,
  output logic [7:0]               o_Tx_Byte,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic                     o_Overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StGuard} state_e;

  state_e          state_q, state_d;
  logic [3:0]      guard_q, guard_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            full_q, empty_q, overflow_q;
  logic [7:0]      tx_byte_q;
  logic [7:0]      mem [DEPTH];
  logic            pop, push;

  // Pop happens on the idle->launch transition; a pop frees a slot, so a
  // write while full is still accepted in that same cycle.
  assign pop  = (state_q == StIdle) && !empty_q && !i_Tx_Active;
  assign push = i_DV && (!full_q || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; gating on rst keeps writes out of the reset cycle.
  always_ff @(posedge i_Clk) begin
    if (push && rst) begin
      mem[wr_ptr_q] <= i_Byte;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of 2.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        tx_byte_q <= mem[rd_ptr_q];
      end
      count_q <= count_d;
      full_q  <= (count_d == FullCount);
      empty_q <= (count_d == '0);
      if (i_DV && !push) overflow_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge i_Clk) begin
    if (!rst) begin
      state_q <= StIdle;
      guard_q <= 4'd0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StLaunch;
      end
      StLaunch: begin
        state_d = StBusy;
      end
      StBusy: begin
        if (i_Tx_Done) begin
          state_d = StGuard;
          guard_d = 4'(CLKS_GUARD);
        end
      end
      StGuard: begin
        if (guard_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          guard_d = guard_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_Tx_DV = (state_q == StLaunch);
  end

  assign o_Tx_Byte  = tx_byte_q;
  assign o_Count    = count_q;
  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer. A behavioural transmitter answers
// each launch after a fixed or random byte time; launched bytes are collected
// in a queue and compared against the queue of bytes the bench expects sent.
module tb_uart_tx_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GUARD = 2;
  localparam int          CW    = $clog2(DEPTH) + 1;

  logic          i_Clk = 1'b0;
  logic          rst;
  logic          i_DV;
  logic [7:0]    i_Byte;
  logic          i_Tx_Active;
  logic          i_Tx_Done;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic [CW-1:0] o_Count;
  logic          o_Full;
  logic          o_Empty;
  logic          o_Overflow;

  int vectors     = 0;
  int miscompares = 0;

  // Transmitter model state
  bit   hold       = 1'b0;
  bit   tx_busy    = 1'b0;
  bit   done_pulse = 1'b0;
  bit   force_done = 1'b0;
  bit   rand_time  = 1'b0;
  bit   check_gap  = 1'b0;
  int   byte_time  = 10;
  int   tx_rem     = 0;
  int   cyc        = 0;
  int   last_done_cyc = -1;

  logic [7:0] launched[$];
  logic [7:0] exp_q[$];

  assign i_Tx_Active = tx_busy | hold;
  assign i_Tx_Done   = done_pulse | force_done;

  uart_tx_buffer #(
    .DEPTH      (DEPTH),
    .CLKS_GUARD (GUARD)
  ) dut (
    .i_Clk       (i_Clk),
    .rst         (rst),
    .i_DV        (i_DV),
    .i_Byte      (i_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_Count     (o_Count),
    .o_Full      (o_Full),
    .o_Empty     (o_Empty),
    .o_Overflow  (o_Overflow)
  );

  always #5 i_Clk = ~i_Clk;

  // Transmitter model and launch monitor, evaluated away from the active edge.
  always @(negedge i_Clk) begin
    cyc = cyc + 1;
    done_pulse = 1'b0;
    if (o_Tx_DV) begin
      launched.push_back(o_Tx_Byte);
      vectors++;
      if (tx_busy) begin
        miscompares++;
        $display("FAIL one_in_flight: launch of %02h while transmitter busy, required idle",
                 o_Tx_Byte);
      end
      // Done sampled at edge E; guard holds GUARD+1 edges, the pop is one
      // edge later, and the launch is seen at the negedge after that.
      if (check_gap && last_done_cyc >= 0) begin
        vectors++;
        if (cyc - last_done_cyc != int'(GUARD) + 3) begin
          miscompares++;
          $display("FAIL guard_gap: %0d cycles from done to launch, required %0d",
                   cyc - last_done_cyc, GUARD + 3);
        end
      end
      tx_busy = 1'b1;
      tx_rem  = rand_time ? int'($urandom_range(1, 8)) : byte_time;
    end else if (tx_busy) begin
      tx_rem = tx_rem - 1;
      if (tx_rem == 0) begin
        tx_busy       = 1'b0;
        done_pulse    = 1'b1;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge i_Clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic drain(input int n, input int budget);
    int k = 0;
    while ((launched.size() < n || tx_busy || !o_Empty) && k < budget) begin
      tick();
      k++;
    end
    repeat (GUARD + 6) tick();
    vectors++;
    if (k >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d launches after %0d cycles, required %0d",
               launched.size(), k, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      i_DV   = 1'($urandom_range(0, 1));
      i_Byte = 8'($urandom);
      tick();
    end
    i_DV = 1'b0;
    vectors += 6;
    if (o_Count !== '0) begin
      miscompares++; $display("FAIL reset_count: got %0d, required 0", o_Count);
    end
    if (o_Empty !== 1'b1) begin
      miscompares++; $display("FAIL reset_empty: got %b, required 1", o_Empty);
    end
    if (o_Full !== 1'b0) begin
      miscompares++; $display("FAIL reset_full: got %b, required 0", o_Full);
    end
    if (o_Overflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_overflow: got %b, required 0", o_Overflow);
    end
    if (o_Tx_DV !== 1'b0) begin
      miscompares++; $display("FAIL reset_tx_dv: got %b, required 0", o_Tx_DV);
    end
    if (o_Tx_Byte !== 8'h00) begin
      miscompares++; $display("FAIL reset_tx_byte: got %02h, required 00", o_Tx_Byte);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    launched.delete();
    byte_time = 10;
    i_DV = 1'b1; i_Byte = 8'hA5;
    tick();
    i_DV = 1'b0;
    vectors += 2;
    if (o_Count !== CW'(1)) begin
      miscompares++; $display("FAIL single_count_after_write: got %0d, required 1", o_Count);
    end
    if (o_Tx_DV !== 1'b0) begin
      miscompares++; $display("FAIL single_no_early_dv: got %b, required 0", o_Tx_DV);
    end
    tick();
    vectors += 3;
    if (o_Tx_DV !== 1'b1) begin
      miscompares++; $display("FAIL single_launch_dv: got %b, required 1", o_Tx_DV);
    end
    if (o_Tx_Byte !== 8'hA5) begin
      miscompares++; $display("FAIL single_launch_byte: got %02h, required a5", o_Tx_Byte);
    end
    if (o_Count !== '0 || o_Empty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_count_after_pop: got %0d/%b, required 0/1", o_Count, o_Empty);
    end
    tick();
    vectors++;
    if (o_Tx_DV !== 1'b0) begin
      miscompares++; $display("FAIL single_dv_width: got %b, required 0", o_Tx_DV);
    end
    drain(1, 200);
  endtask

  task automatic test_burst();
    launched.delete();
    exp_q.delete();
    byte_time     = 4340;
    last_done_cyc = -1;
    check_gap     = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      i_DV = 1'b1; i_Byte = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    i_DV = 1'b0;
    drain(5, 30000);
    check_gap = 1'b0;
    byte_time = 10;
    vectors++;
    if (launched.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL burst_len: got %0d, required %0d", launched.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < launched.size(); i++) begin
      vectors++;
      if (launched[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL burst_order[%0d]: got %02h, required %02h", i, launched[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    do_reset();
    launched.delete();
    exp_q.delete();
    hold = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 3; i++) begin
      b = 8'($urandom);
      i_DV = 1'b1; i_Byte = b;
      if (i < int'(DEPTH)) exp_q.push_back(b);
      tick();
    end
    i_DV = 1'b0;
    vectors += 4;
    if (o_Full !== 1'b1) begin
      miscompares++; $display("FAIL ovf_full: got %b, required 1", o_Full);
    end
    if (o_Count !== CW'(DEPTH)) begin
      miscompares++; $display("FAIL ovf_count: got %0d, required %0d", o_Count, DEPTH);
    end
    if (o_Overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_flag: got %b, required 1", o_Overflow);
    end
    if (launched.size() != 0) begin
      miscompares++; $display("FAIL ovf_held: got %0d launches, required 0", launched.size());
    end
    hold = 1'b0;
    drain(DEPTH, 3000);
    vectors += 2;
    if (launched.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL ovf_len: got %0d, required %0d", launched.size(), exp_q.size());
    end
    if (o_Overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_sticky: got %b, required 1", o_Overflow);
    end
    for (int i = 0; i < exp_q.size() && i < launched.size(); i++) begin
      vectors++;
      if (launched[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ovf_data[%0d]: got %02h, required %02h", i, launched[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] b;
    do_reset();
    launched.delete();
    exp_q.delete();
    hold = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      b = 8'($urandom);
      i_DV = 1'b1; i_Byte = b;
      exp_q.push_back(b);
      tick();
    end
    // Release the transmitter and write in the cycle the pop happens.
    b = 8'($urandom);
    hold = 1'b0;
    i_DV = 1'b1; i_Byte = b;
    exp_q.push_back(b);
    tick();
    i_DV = 1'b0;
    vectors += 4;
    if (o_Count !== CW'(DEPTH)) begin
      miscompares++; $display("FAIL pp_count: got %0d, required %0d", o_Count, DEPTH);
    end
    if (o_Full !== 1'b1) begin
      miscompares++; $display("FAIL pp_full: got %b, required 1", o_Full);
    end
    if (o_Overflow !== 1'b0) begin
      miscompares++; $display("FAIL pp_overflow: got %b, required 0", o_Overflow);
    end
    if (o_Tx_DV !== 1'b1) begin
      miscompares++; $display("FAIL pp_launch: got %b, required 1", o_Tx_DV);
    end
    drain(DEPTH + 1, 3000);
    vectors++;
    if (launched.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL pp_len: got %0d, required %0d", launched.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < launched.size(); i++) begin
      vectors++;
      if (launched[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL pp_data[%0d]: got %02h, required %02h", i, launched[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    launched.delete();
    byte_time = 200;
    for (int i = 0; i < 4; i++) begin
      i_DV = 1'b1; i_Byte = 8'h11 + 8'(i);
      tick();
    end
    i_DV = 1'b0;
    repeat (10) tick();
    vectors += 2;
    if (launched.size() != 1) begin
      miscompares++; $display("FAIL rmb_one_launch: got %0d, required 1", launched.size());
    end
    if (o_Count !== CW'(3)) begin
      miscompares++; $display("FAIL rmb_queued: got %0d, required 3", o_Count);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vectors += 2;
    if (o_Count !== '0 || o_Empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rmb_flushed: got %0d/%b, required 0/1", o_Count, o_Empty);
    end
    if (o_Tx_DV !== 1'b0) begin
      miscompares++; $display("FAIL rmb_dv: got %b, required 0", o_Tx_DV);
    end
    // The in-flight byte finishes and raises done while the block is idle.
    repeat (300) tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    vectors++;
    if (launched.size() != 1) begin
      miscompares++;
      $display("FAIL rmb_no_relaunch: got %0d launches, required 1", launched.size());
    end
    byte_time = 10;
    i_DV = 1'b1; i_Byte = 8'h77;
    tick();
    i_DV = 1'b0;
    drain(2, 500);
    vectors++;
    if (launched.size() != 2 || launched[launched.size()-1] !== 8'h77) begin
      miscompares++;
      $display("FAIL rmb_resume: got %0d launches last %02h, required 2 last 77",
               launched.size(), launched[launched.size()-1]);
    end
  endtask

  task automatic test_wrap();
    int n = 3 * int'(DEPTH) + 1;
    int pushed = 0;
    int k = 0;
    do_reset();
    launched.delete();
    exp_q.delete();
    rand_time = 1'b1;
    while (pushed < n && k < 5000) begin
      if ($urandom_range(0, 1) == 1 && (pushed - launched.size()) < int'(DEPTH) - 1) begin
        i_DV = 1'b1; i_Byte = 8'(pushed + 8'h30);
        exp_q.push_back(8'(pushed + 8'h30));
        pushed++;
      end else begin
        i_DV = 1'b0;
      end
      tick();
      k++;
    end
    i_DV = 1'b0;
    drain(n, 3000);
    rand_time = 1'b0;
    vectors += 2;
    if (launched.size() != n) begin
      miscompares++; $display("FAIL wrap_len: got %0d, required %0d", launched.size(), n);
    end
    if (o_Overflow !== 1'b0) begin
      miscompares++; $display("FAIL wrap_overflow: got %b, required 0", o_Overflow);
    end
    for (int i = 0; i < exp_q.size() && i < launched.size(); i++) begin
      vectors++;
      if (launched[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL wrap_data[%0d]: got %02h, required %02h", i, launched[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; i_DV = 1'b0; i_Byte = 8'h00;
    tick();
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_busy();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
